mul_outer_seq: RTL and testbench
================================

MUL_OUTER_SEQ -- requirements
Module: mul_outer_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; signed two's complement.
REQ-002 Parameter DEPTH, default 4: bit-index width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 i_valid  input  1  request: operand pair present on i_data0/i_data1.
REQ-006 o_ready  output  1  block can accept a request this cycle.
REQ-007 i_data0  input  WIDTH  signed multiplier, scanned bit-serially.
REQ-008 i_data1  input  WIDTH  signed multiplicand.
REQ-009 o_op0  output  WIDTH  latched multiplier, to partial-product unit.
REQ-010 o_op1  output  WIDTH  latched multiplicand, to partial-product unit.
REQ-011 o_pp_idx  output  DEPTH  bit index issued to partial-product unit.
REQ-012 o_pp_en  output  1  index-capture enable to partial-product unit.
REQ-013 o_pp_clr  output  1  index clear to partial-product unit.
REQ-014 i_pp  input  2*WIDTH  signed partial product: o_op1 sign-extended if o_op0[captured index]=1, else 0; valid the cycle after capture.
REQ-015 o_valid  output  1  product valid.
REQ-016 i_ready  input  1  downstream accepts product.
REQ-017 o_data  output  2*WIDTH  signed product.
REQ-018 o_busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: o_ready=1, o_pp_clr=1, o_pp_en=0; on i_valid -> latch i_data0/i_data1 into o_op0/o_op1, clear accumulator and counter, go RUN.
REQ-021 RUN: o_pp_en=1, o_pp_idx=counter; counter increments each cycle; after index WIDTH-1 is issued, go DRAIN.
REQ-022 DRAIN: o_pp_en=0; one cycle; go DONE.
REQ-023 Accumulate flag SHALL be o_pp_en delayed one cycle; the index tag SHALL be o_pp_idx delayed one cycle.
REQ-024 When flag set with tag k < WIDTH-1: acc <= acc + (i_pp << k); with tag k = WIDTH-1: acc <= acc - (i_pp << k) (sign weight).
REQ-025 Accumulator SHALL be 2*WIDTH bits, arithmetic modulo 2^(2*WIDTH); exact for all signed operand pairs including -2^(WIDTH-1) squared.
REQ-026 DONE: o_valid=1, o_data=acc, held stable until i_ready; on i_valid&&... not applicable, o_ready=0; on i_ready -> IDLE.
REQ-027 Latency: accept edge E0 -> o_valid high after edge E0+WIDTH+1 (17 cycles for WIDTH=16).
REQ-028 Throughput: one product per WIDTH+3 cycles with i_ready held high (one IDLE bubble).
REQ-029 i_valid while o_ready=0 SHALL be ignored; operands and accumulator unaffected.
REQ-030 o_pp_clr and o_pp_en SHALL never be high in the same cycle.
REQ-031 o_data SHALL equal the accumulator in all states; it is meaningful only while o_valid=1.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE and zero counter, accumulator, flag, tag, o_op0, o_op1, o_pp_idx; takes priority over every other event.
REQ-033 Reset outputs: o_ready=1, o_pp_clr=1, o_pp_en=0, o_valid=0, o_busy=0, o_data=0.
REQ-034 rst mid-operation (RUN/DRAIN/DONE) SHALL abort with no o_valid pulse; next request after rst release processes normally.

Verification
REQ-035 i_data0=3, i_data1=5, i_ready=1 -> o_valid after edge E0+17, o_data=15, one-cycle pulse.
REQ-036 i_data0=-1, i_data1=-1 -> o_data=1; i_data0=7, i_data1=-2 -> o_data=-14 (0xFFFFFFF2).
REQ-037 i_data0=i_data1=-32768 -> o_data=0x40000000; i_data0=-32768, i_data1=32767 -> o_data=0xC0008000.
REQ-038 i_ready=0 for 10 cycles in DONE -> o_valid and o_data stable; o_ready=0; i_valid with new operands ignored; first i_ready -> IDLE next cycle.
REQ-039 rst asserted at RUN counter=8 -> next cycle all outputs at reset values; new request 2*3 -> o_data=6 at normal latency.
REQ-040 Back-to-back requests with i_ready=1 -> accepts spaced 19 cycles; o_pp_en high exactly 16 cycles per request, idx 0..15 in order.

Source files
------------

// File: rtl/mul_outer_seq_if.sv
// -----------------------------------------------------------------------------
// mul_outer_seq_if
//   Request/response handshake bundle for the bit-serial signed multiplier.
//
//   Request side  : i_valid, i_data0 (multiplier), i_data1 (multiplicand),
//                   o_ready (block can take a new operand pair).
//   Response side : o_valid, o_data (2*WIDTH signed product),
//                   i_ready (downstream takes the product).
//
//   Modports
//     master : the client that issues operands and consumes products.
//     slave  : the multiplier itself.
// -----------------------------------------------------------------------------
interface mul_outer_seq_if #(
   parameter int WIDTH = 16
);
   logic                 i_valid;
   logic                 o_ready;
   logic [WIDTH-1:0]     i_data0;
   logic [WIDTH-1:0]     i_data1;
   logic                 o_valid;
   logic                 i_ready;
   logic [2*WIDTH-1:0]   o_data;

   modport master (
      output i_valid,
      output i_data0,
      output i_data1,
      output i_ready,
      input  o_ready,
      input  o_valid,
      input  o_data
   );

   modport slave (
      input  i_valid,
      input  i_data0,
      input  i_data1,
      input  i_ready,
      output o_ready,
      output o_valid,
      output o_data
   );
endinterface

// File: rtl/mul_outer_seq.sv
// -----------------------------------------------------------------------------
// mul_outer_seq
//   Sequencer for a bit-serial signed (two's complement) multiplier. It
//   latches an operand pair, walks the multiplier bit index 0..WIDTH-1 out
//   to an external partial-product unit, and accumulates the partial
//   products that come back one cycle later into a 2*WIDTH accumulator.
//   The top bit of the multiplier carries negative weight, so its partial
//   product is subtracted instead of added.
//
//   Ports
//     clk, rst   : clock, synchronous active-high reset
//     bus        : request/response handshake (slave modport)
//     o_op0      : latched multiplier for the partial-product unit
//     o_op1      : latched multiplicand for the partial-product unit
//     o_pp_idx   : multiplier bit index issued this cycle
//     o_pp_en    : partial-product unit captures o_pp_idx this cycle
//     o_pp_clr   : partial-product unit clears its captured index
//     i_pp       : sign-extended partial product for the captured index,
//                  valid the cycle after capture
//     o_busy     : sequencer is not idle
//
//   Timing (WIDTH=16): accept at edge E0, indices issued in the 16 RUN
//   cycles, one DRAIN cycle for the last returning partial product, o_valid
//   high after edge E0+17. With i_ready held high a new request can be
//   accepted every WIDTH+3 cycles.
// -----------------------------------------------------------------------------
module mul_outer_seq #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mul_outer_seq_if.slave       bus,
   output logic [WIDTH-1:0]     o_op0,
   output logic [WIDTH-1:0]     o_op1,
   output logic [DEPTH-1:0]     o_pp_idx,
   output logic                 o_pp_en,
   output logic                 o_pp_clr,
   input  logic [2*WIDTH-1:0]   i_pp,
   output logic                 o_busy
);

   localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_reg, state_next;
   logic [DEPTH-1:0]     cnt_reg,   cnt_next;
   logic [2*WIDTH-1:0]   acc_reg,   acc_next;
   logic [WIDTH-1:0]     op0_reg,   op0_next;
   logic [WIDTH-1:0]     op1_reg,   op1_next;

   // Accumulate flag and index tag: the issued enable/index delayed by one
   // cycle so they line up with the partial product returned by the unit.
   logic                 flag_reg;
   logic [DEPTH-1:0]     tag_reg;

   logic                 ready_c;
   logic                 valid_c;
   logic                 pp_en_c;
   logic                 pp_clr_c;
   logic [2*WIDTH-1:0]   term_c;

   // -------------------------------------------------------------------------
   // Weighted partial product: i_pp shifted by every possible bit position,
   // selected by the tag of the index that produced it. Bits shifted past
   // the top of the accumulator are dropped (arithmetic modulo 2^(2*WIDTH)).
   // -------------------------------------------------------------------------
   logic [2*WIDTH-1:0] shift_tbl [WIDTH];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         assign shift_tbl[gi] = i_pp << gi;
      end
   endgenerate

   assign term_c = shift_tbl[tag_reg];

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         op0_reg   <= '0;
         op1_reg   <= '0;
         flag_reg  <= 1'b0;
         tag_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         acc_reg   <= acc_next;
         op0_reg   <= op0_next;
         op1_reg   <= op1_next;
         flag_reg  <= pp_en_c;
         tag_reg   <= cnt_reg;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      acc_next   = acc_reg;
      op0_next   = op0_reg;
      op1_next   = op1_reg;
      ready_c    = 1'b0;
      valid_c    = 1'b0;
      pp_en_c    = 1'b0;
      pp_clr_c   = 1'b0;

      // A returning partial product is folded in regardless of state; this
      // covers the RUN cycles and the single DRAIN cycle. The sign bit of
      // the multiplier has weight -2^(WIDTH-1), hence the subtraction.
      if (flag_reg) begin
         if (tag_reg == LAST_IDX) begin
            acc_next = acc_reg - term_c;
         end else begin
            acc_next = acc_reg + term_c;
         end
      end

      case (state_reg)
         IDLE: begin
            ready_c  = 1'b1;
            pp_clr_c = 1'b1;
            if (bus.i_valid) begin
               op0_next   = bus.i_data0;
               op1_next   = bus.i_data1;
               acc_next   = '0;
               cnt_next   = '0;
               state_next = RUN;
            end
         end

         RUN: begin
            pp_en_c  = 1'b1;
            cnt_next = cnt_reg + DEPTH'(1);
            if (cnt_reg == LAST_IDX) begin
               state_next = DRAIN;
            end
         end

         DRAIN: begin
            // Only here to let the last partial product arrive and be added.
            state_next = DONE;
         end

         DONE: begin
            valid_c = 1'b1;
            if (bus.i_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.o_ready = ready_c;
   assign bus.o_valid = valid_c;
   assign bus.o_data  = acc_reg;

   assign o_op0    = op0_reg;
   assign o_op1    = op1_reg;
   assign o_pp_idx = cnt_reg;
   assign o_pp_en  = pp_en_c;
   assign o_pp_clr = pp_clr_c;
   assign o_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_outer_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_outer_seq
//   Self-checking bench for mul_outer_seq. A small behavioural partial-product
//   unit closes the loop; results are compared against a table of known
//   products and against plain integer multiplication for random operands.
// -----------------------------------------------------------------------------
module tb_mul_outer_seq;

   localparam int W = 16;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mul_outer_seq_if #(.WIDTH(W)) bus ();

   logic [W-1:0]   op0;
   logic [W-1:0]   op1;
   logic [D-1:0]   pp_idx;
   logic           pp_en;
   logic           pp_clr;
   logic [2*W-1:0] pp;
   logic           busy;

   mul_outer_seq #(.WIDTH(W), .DEPTH(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .o_op0    (op0),
      .o_op1    (op1),
      .o_pp_idx (pp_idx),
      .o_pp_en  (pp_en),
      .o_pp_clr (pp_clr),
      .i_pp     (pp),
      .o_busy   (busy)
   );

   // Partial-product unit: captures the index on enable, clears on clear,
   // returns the sign-extended multiplicand when the selected bit is set.
   logic [D-1:0] pp_cap = '0;
   always @(posedge clk) begin
      if (pp_clr)     pp_cap <= '0;
      else if (pp_en) pp_cap <= pp_idx;
   end
   assign pp = op0[pp_cap] ? {{W{op1[W-1]}}, op1} : '0;

   int   n_cmp   = 0;
   int   n_fail  = 0;
   int   mon_idx = 0;
   int   en_cnt  = 0;
   logic prev_valid = 1'b0;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[2*W-1:0];
   endfunction

   // One clock, sampled 1 time unit after the edge; also tracks the index
   // stream issued to the partial-product unit.
   task automatic tick();
      @(posedge clk);
      #1;
      if (pp_en) begin
         check("pp_idx_order", 64'(pp_idx), 64'(mon_idx));
         check("pp_clr_en_exclusive", 64'(pp_clr), 64'd0);
         mon_idx++;
         en_cnt++;
      end
      if (bus.o_valid && !prev_valid) begin
         check("pp_en_count", 64'(en_cnt), 64'(W));
         en_cnt  = 0;
         mon_idx = 0;
      end
      prev_valid = bus.o_valid;
   endtask

   task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      while (!bus.o_ready && n < 50) begin
         tick();
         n++;
      end
      check("ready_before_request", 64'(bus.o_ready), 64'd1);
      bus.i_valid = 1'b1;
      bus.i_data0 = a;
      bus.i_data1 = b;
      tick();
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.o_valid && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
      int n;
      start_req(a, b);
      wait_valid(n);
      check({name, "_latency"}, 64'(n), 64'(W + 1));
      check({name, "_data"}, 64'(bus.o_data), 64'(exp));
      $display("txn %s: a=%0d b=%0d -> 0x%h (latency %0d)", name, $signed(a), $signed(b), bus.o_data, n);
      tick();
      check({name, "_pulse"}, 64'(bus.o_valid), 64'd0);
   endtask

   initial begin
      int             n;
      logic           seen;
      logic [W-1:0]   ra, rb;
      logic [2*W-1:0] exp_v;
      logic [2*W-1:0] exp_q [$];
      int             acc_cyc [$];
      int             k, got;
      logic           accepting;

      vecs[0] = '{16'd3,      16'd5,      32'd15};
      vecs[1] = '{16'hFFFF,   16'hFFFF,   32'd1};
      vecs[2] = '{16'd7,      16'hFFFE,   32'hFFFF_FFF2};
      vecs[3] = '{16'h8000,   16'h8000,   32'h4000_0000};
      vecs[4] = '{16'h8000,   16'h7FFF,   32'hC000_8000};
      vecs[5] = '{16'h7FFF,   16'h7FFF,   32'h3FFF_0001};
      vecs[6] = '{16'h1234,   16'h0000,   32'h0000_0000};
      vecs[7] = '{16'hFFFB,   16'd3,      32'hFFFF_FFF1};

      bus.i_valid = 1'b0;
      bus.i_data0 = '0;
      bus.i_data1 = '0;
      bus.i_ready = 1'b1;

      // Reset values
      rst = 1'b1;
      repeat (3) tick();
      check("rst_o_ready",  64'(bus.o_ready), 64'd1);
      check("rst_pp_clr",   64'(pp_clr),      64'd1);
      check("rst_pp_en",    64'(pp_en),       64'd0);
      check("rst_o_valid",  64'(bus.o_valid), 64'd0);
      check("rst_o_busy",   64'(busy),        64'd0);
      check("rst_o_data",   64'(bus.o_data),  64'd0);
      check("rst_o_op0",    64'(op0),         64'd0);
      check("rst_pp_idx",   64'(pp_idx),      64'd0);
      rst = 1'b0;
      tick();

      // Table of known products
      for (int i = 0; i < 8; i++) begin
         run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Back-pressure in DONE: output held, new requests ignored
      bus.i_ready = 1'b0;
      start_req(16'd100, 16'hFFFD);
      wait_valid(n);
      check("bp_latency", 64'(n), 64'(W + 1));
      exp_v = model(16'd100, 16'hFFFD);
      for (int i = 0; i < 10; i++) begin
         check("bp_o_valid", 64'(bus.o_valid), 64'd1);
         check("bp_o_data",  64'(bus.o_data),  64'(exp_v));
         check("bp_o_ready", 64'(bus.o_ready), 64'd0);
         bus.i_valid = 1'b1;
         bus.i_data0 = 16'($urandom);
         bus.i_data1 = 16'($urandom);
         tick();
      end
      check("bp_o_data_end", 64'(bus.o_data), 64'(exp_v));
      $display("txn backpressure: a=100 b=-3 -> 0x%h held 10 cycles", bus.o_data);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      tick();
      check("bp_release_valid", 64'(bus.o_valid), 64'd0);
      check("bp_release_idle",  64'(busy),        64'd0);
      check("bp_op0_kept",      64'(op0),         64'd100);
      check("bp_op1_kept",      64'(op1),         64'hFFFD);

      // Reset in the middle of RUN
      start_req(16'd9, 16'd9);
      n = 0;
      while (!(pp_en && pp_idx == 4'd8) && n < 30) begin
         tick();
         n++;
      end
      check("abort_reached_idx8", 64'(pp_idx), 64'd8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_o_ready", 64'(bus.o_ready), 64'd1);
      check("abort_pp_clr",  64'(pp_clr),      64'd1);
      check("abort_pp_en",   64'(pp_en),       64'd0);
      check("abort_o_valid", 64'(bus.o_valid), 64'd0);
      check("abort_o_busy",  64'(busy),        64'd0);
      check("abort_o_data",  64'(bus.o_data),  64'd0);
      check("abort_o_op0",   64'(op0),         64'd0);
      check("abort_o_op1",   64'(op1),         64'd0);
      check("abort_pp_idx",  64'(pp_idx),      64'd0);
      $display("txn abort: reset at index 8");
      mon_idx = 0;
      en_cnt  = 0;
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (bus.o_valid) seen = 1'b1;
      end
      check("abort_no_valid", 64'(seen), 64'd0);
      run_mul("after_abort", 16'd2, 16'd3, 32'd6);

      // Back-to-back with i_valid held high
      k = 0;
      got = 0;
      ra = 16'($urandom);
      rb = 16'($urandom);
      bus.i_valid = 1'b1;
      bus.i_data0 = ra;
      bus.i_data1 = rb;
      for (int c = 0; c < 80; c++) begin
         accepting = bus.o_ready && bus.i_valid;
         if (accepting) begin
            exp_q.push_back(model(ra, rb));
            acc_cyc.push_back(c);
         end
         if (bus.o_valid) begin
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            else                  exp_v = 'x;
            check("b2b_data", 64'(bus.o_data), 64'(exp_v));
            $display("txn b2b%0d: -> 0x%h", got, bus.o_data);
            got++;
         end
         tick();
         if (accepting) begin
            k++;
            if (k < 3) begin
               ra = 16'($urandom);
               rb = 16'($urandom);
               bus.i_data0 = ra;
               bus.i_data1 = rb;
            end else begin
               bus.i_valid = 1'b0;
            end
         end
      end
      check("b2b_accepts", 64'(acc_cyc.size()), 64'd3);
      check("b2b_results", 64'(got), 64'd3);
      if (acc_cyc.size() == 3) begin
         check("b2b_spacing0", 64'(acc_cyc[1] - acc_cyc[0]), 64'(W + 3));
         check("b2b_spacing1", 64'(acc_cyc[2] - acc_cyc[1]), 64'(W + 3));
      end

      // Random operands against integer multiplication
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_mul($sformatf("rand%0d", i), ra, rb, model(ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
